// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader and the debug unit.
package instruction_loader_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    localparam int          BYTE_CNT_W = 2;
    localparam logic [31:0] HALT_WORD  = 32'h0000_0000;
endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Shifts received bytes MSB-first into an instruction word; flags the final byte slot.
module word_assembler
    import instruction_loader_pkg::*;
#(
    parameter int CANT_BITS_INSTRUCTION = 32,
    parameter int CANT_BITS_DATO_UART   = 8
) (
    input  logic                             i_clock,
    input  logic                             i_soft_reset,
    input  logic                             i_clear,
    input  logic                             i_load,
    input  logic [CANT_BITS_DATO_UART-1:0]   i_byte,
    output logic [CANT_BITS_INSTRUCTION-1:0] o_word,
    output logic                             o_last
);
    logic [CANT_BITS_INSTRUCTION-1:0] word_q, word_d;
    logic [BYTE_CNT_W-1:0]            cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (i_clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (i_load) begin
            // Older bytes move toward the MSB, so byte 0 ends up in the top slot.
            word_d = {word_q[CANT_BITS_INSTRUCTION-CANT_BITS_DATO_UART-1:0], i_byte};
            cnt_d  = cnt_q + BYTE_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_word = word_q;
    assign o_last = &cnt_q;
endmodule

// File: rtl/instruction_loader.sv
// Loads a program byte-by-byte into instruction memory, stopping on HALT or address overflow.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int CANT_BITS_INSTRUCTION = 32,
    parameter int CANT_BITS_DATO_UART   = 8,
    parameter int CANT_BITS_ADDR        = 11
) (
    input  logic                             i_clock,
    input  logic                             i_soft_reset,
    input  logic                             i_start,
    input  logic [CANT_BITS_DATO_UART-1:0]   i_rx_data,
    input  logic                             i_rx_valid,
    output logic                             o_mem_write_enable,
    output logic [CANT_BITS_ADDR-1:0]        o_mem_addr,
    output logic [CANT_BITS_INSTRUCTION-1:0] o_mem_data,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_error,
    output logic [CANT_BITS_ADDR:0]          o_instr_count
);
    localparam logic [CANT_BITS_ADDR-1:0] ADDR_MAX = '1;

    state_e                    state_q, state_d;
    logic [CANT_BITS_ADDR-1:0] addr_q, addr_d;
    logic [CANT_BITS_ADDR:0]   count_q, count_d;
    logic                      we_q, we_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                      start_ok, load, last, is_halt;
    logic [CANT_BITS_INSTRUCTION-1:0] word;

    assign is_halt  = (word == CANT_BITS_INSTRUCTION'(HALT_WORD));
    assign start_ok = i_start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
    // A byte landing in the WRITE cycle starts the next word unless this word is HALT.
    assign load     = i_rx_valid && ((state_q == ST_RECV) || (state_q == ST_WRITE && !is_halt));

    word_assembler #(
        .CANT_BITS_INSTRUCTION(CANT_BITS_INSTRUCTION),
        .CANT_BITS_DATO_UART  (CANT_BITS_DATO_UART)
    ) u_asm (
        .i_clock     (i_clock),
        .i_soft_reset(i_soft_reset),
        .i_clear     (start_ok),
        .i_load      (load),
        .i_byte      (i_rx_data),
        .o_word      (word),
        .o_last      (last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_ok) begin
                    state_d = ST_RECV;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            ST_RECV:  if (load && last) state_d = ST_WRITE;
            ST_WRITE: begin
                count_d = count_q + 1'b1;
                if (is_halt)                  state_d = ST_DONE;
                else if (addr_q == ADDR_MAX)  state_d = ST_ERROR;
                else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_RECV;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        we_d    = (state_d == ST_WRITE);
        busy_d  = (state_d == ST_RECV) || (state_d == ST_WRITE);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign o_mem_write_enable = we_q;
    assign o_mem_addr         = addr_q;
    assign o_mem_data         = word;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_error            = error_q;
    assign o_instr_count      = count_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Randomized and directed checks of instruction_loader against a word-level program model.
module tb_instruction_loader;
    localparam int A  = 11;
    localparam int SA = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, rx_valid = 1'b0, s_start = 1'b0, s_rx_valid = 1'b0;
    logic [7:0] rx_data = '0, s_rx_data = '0;
    logic we, busy, done, err, s_we, s_busy, s_done, s_err;
    logic [A-1:0] addr;
    logic [SA-1:0] s_addr;
    logic [31:0] data, s_data;
    logic [A:0] cnt;
    logic [SA:0] s_cnt;

    always #5 clk = ~clk;

    instruction_loader dut (
        .i_clock(clk), .i_soft_reset(rst_n), .i_start(start), .i_rx_data(rx_data),
        .i_rx_valid(rx_valid), .o_mem_write_enable(we), .o_mem_addr(addr), .o_mem_data(data),
        .o_busy(busy), .o_done(done), .o_error(err), .o_instr_count(cnt));

    instruction_loader #(.CANT_BITS_ADDR(SA)) dut_s (
        .i_clock(clk), .i_soft_reset(rst_n), .i_start(s_start), .i_rx_data(s_rx_data),
        .i_rx_valid(s_rx_valid), .o_mem_write_enable(s_we), .o_mem_addr(s_addr), .o_mem_data(s_data),
        .o_busy(s_busy), .o_done(s_done), .o_error(s_err), .o_instr_count(s_cnt));

    int vectors = 0, miscompares = 0;
    logic [63:0] got_q[$], s_got_q[$], exp_q[$], tmp_q[$];
    logic [31:0] words_q[$];
    logic exp_done, exp_err;

    always @(negedge clk) begin
        if (we === 1'b1)   got_q.push_back({32'(addr), data});
        if (s_we === 1'b1) s_got_q.push_back({32'(s_addr), s_data});
    end

    // Program model: word i goes to address i; stops after HALT or after the last address.
    function automatic void model(input int aw);
        exp_q.delete(); exp_done = 1'b0; exp_err = 1'b0;
        foreach (words_q[i]) begin
            exp_q.push_back({32'(i), words_q[i]});
            if (words_q[i] == 32'h0) begin exp_done = 1'b1; break; end
            if (i == (1 << aw) - 1) begin exp_err = 1'b1; break; end
        end
    endfunction

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) s_start = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; s_start = 1'b0;
    endtask

    // Starts at a falling edge; returns at the falling edge right after the last byte is sampled.
    task automatic drive_words(input bit sel, input int gap_max);
        logic [31:0] w;
        logic [7:0] b;
        int g;
        foreach (words_q[i]) begin
            w = words_q[i];
            for (int k = 0; k < 4; k++) begin
                b = w[31-8*k -: 8];
                if (sel) begin s_rx_valid = 1'b1; s_rx_data = b; end
                else begin rx_valid = 1'b1; rx_data = b; end
                @(negedge clk);
                rx_valid = 1'b0; s_rx_valid = 1'b0;
                if (!(i == words_q.size() - 1 && k == 3)) begin
                    g = $urandom_range(gap_max, 0);
                    repeat (g) @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++; if ({we, busy, done, err} !== 4'b0) begin miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {we, busy, done, err}); end
        vectors++; if (addr !== '0 || data !== '0 || cnt !== '0) begin miscompares++;
            $display("FAIL reset_regs: got addr=%h data=%h cnt=%h want 0", addr, data, cnt); end
        vectors++; if ({s_we, s_busy, s_done, s_err, s_addr, s_cnt} !== '0) begin miscompares++;
            $display("FAIL reset_small: got nonzero outputs want 0"); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0 || we !== 1'b0) begin miscompares++;
            $display("FAIL idle_after_reset: got busy=%b we=%b want 0 0", busy, we); end
    endtask

    task automatic test_single_word;
        got_q.delete();
        pulse_start(0);
        words_q = '{32'h000110C0};
        drive_words(0, 0);
        vectors++; if (we !== 1'b1 || addr !== '0 || data !== 32'h000110C0) begin miscompares++;
            $display("FAIL single_write: got we=%b addr=%h data=%h want 1 0 000110c0", we, addr, data); end
        @(negedge clk);
        vectors++; if (we !== 1'b0 || cnt !== 12'd1) begin miscompares++;
            $display("FAIL single_after: got we=%b cnt=%0d want 0 1", we, cnt); end
        vectors++; if ({busy, done, err} !== 3'b100) begin miscompares++;
            $display("FAIL single_state: got bde=%b want 100", {busy, done, err}); end
        vectors++; if (got_q.size() != 1) begin miscompares++;
            $display("FAIL single_strobes: got %0d want 1", got_q.size()); end
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_halt_program;
        got_q.delete();
        pulse_start(0);
        words_q = '{32'h00221804};
        drive_words(0, 0);
        pulse_start(0);  // lands in RECV; must not restart
        words_q = '{32'h1283000C, 32'h00000000};
        drive_words(0, 1);
        repeat (3) @(negedge clk);
        words_q = '{32'h00221804, 32'h1283000C, 32'h00000000};
        model(A);
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++;
            $display("FAIL halt_nwrites: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++;
                $display("FAIL halt_write%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vectors++; if ({busy, done, err} !== 3'b010 || cnt !== 12'd3) begin miscompares++;
            $display("FAIL halt_final: got bde=%b cnt=%0d want 010 3", {busy, done, err}, cnt); end
    endtask

    task automatic test_back_to_back;
        got_q.delete();
        pulse_start(0);
        words_q = '{32'h00221821, 32'h8C010004, 32'hAC020008, 32'h00000000, 32'h55AA55AA};
        drive_words(0, 0);
        repeat (3) @(negedge clk);
        model(A);
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++;
            $display("FAIL b2b_nwrites: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++;
                $display("FAIL b2b_write%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        vectors++; if (done !== 1'b1 || cnt !== 12'(exp_q.size())) begin miscompares++;
            $display("FAIL b2b_final: got done=%b cnt=%0d want 1 %0d", done, cnt, exp_q.size()); end
    endtask

    task automatic test_overflow;
        logic [31:0] w;
        s_got_q.delete();
        pulse_start(1);
        words_q.delete();
        for (int i = 0; i < 5; i++) begin w = $urandom; if (w == 0) w = 1; words_q.push_back(w); end
        drive_words(1, 2);
        repeat (4) @(negedge clk);
        model(SA);
        vectors++; if (s_got_q.size() != 4 || exp_q.size() != 4) begin miscompares++;
            $display("FAIL ovf_nwrites: got %0d want 4", s_got_q.size()); end
        foreach (exp_q[i]) if (i < s_got_q.size()) begin
            vectors++; if (s_got_q[i] !== exp_q[i]) begin miscompares++;
                $display("FAIL ovf_write%0d: got %h want %h", i, s_got_q[i], exp_q[i]); end
        end
        vectors++; if ({s_busy, s_done, s_err} !== 3'b001 || s_cnt !== 3'd4 || s_addr !== 2'd3) begin
            miscompares++;
            $display("FAIL ovf_final: got bde=%b cnt=%0d addr=%0d want 001 4 3", {s_busy, s_done, s_err}, s_cnt, s_addr); end
    endtask

    task automatic test_reset_midword;
        got_q.delete();
        pulse_start(0);
        rx_valid = 1'b1; rx_data = 8'hAB; @(negedge clk);
        rx_data = 8'hCD; @(negedge clk);
        rx_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++;
            $display("FAIL mid_busy: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({we, busy, done, err, addr, data, cnt} !== '0) begin miscompares++;
            $display("FAIL mid_reset: got we=%b busy=%b data=%h cnt=%0d want 0", we, busy, data, cnt); end
        @(negedge clk); rst_n = 1'b1;
        pulse_start(0);
        words_q = '{32'h12345678};
        drive_words(0, 0);
        vectors++; if (we !== 1'b1 || addr !== '0 || data !== 32'h12345678) begin miscompares++;
            $display("FAIL mid_reload: got we=%b addr=%h data=%h want 1 0 12345678", we, addr, data); end
        #2 rst_n = 1'b0;  // reset during WRITE
        #1;
        vectors++; if (we !== 1'b0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL write_reset: got we=%b busy=%b want 0 0", we, busy); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (got_q.size() != 1) begin miscompares++;
            $display("FAIL mid_strobes: got %0d want 1", got_q.size()); end
    endtask

    task automatic test_idle_done_rx;
        got_q.delete();
        words_q = '{32'hDEADBEEF};
        drive_words(0, 1);
        repeat (2) @(negedge clk);
        vectors++; if (got_q.size() != 0 || cnt !== '0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL idle_rx: got writes=%0d cnt=%0d busy=%b want 0 0 0", got_q.size(), cnt, busy); end
        pulse_start(0);
        words_q = '{32'h00000000};
        drive_words(0, 0);
        repeat (2) @(negedge clk);
        got_q.delete();
        words_q = '{32'h11223344};
        drive_words(0, 1);
        repeat (2) @(negedge clk);
        vectors++; if (got_q.size() != 0 || cnt !== 12'd1 || done !== 1'b1) begin miscompares++;
            $display("FAIL done_rx: got writes=%0d cnt=%0d done=%b want 0 1 1", got_q.size(), cnt, done); end
    endtask

    task automatic test_random;
        logic [31:0] w;
        bit sel;
        int n;
        for (int it = 0; it < 10; it++) begin
            sel = it[0];
            n = $urandom_range(6, 1);
            words_q.delete();
            for (int i = 0; i < n; i++) begin w = $urandom; if (w == 0) w = 32'h1; words_q.push_back(w); end
            words_q.push_back(32'h0);
            got_q.delete(); s_got_q.delete();
            pulse_start(sel);
            drive_words(sel, 2);
            repeat (3) @(negedge clk);
            model(sel ? SA : A);
            if (sel) tmp_q = s_got_q; else tmp_q = got_q;
            vectors++; if (tmp_q.size() != exp_q.size()) begin miscompares++;
                $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, tmp_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < tmp_q.size()) begin
                vectors++; if (tmp_q[i] !== exp_q[i]) begin miscompares++;
                    $display("FAIL rnd%0d_write%0d: got %h want %h", it, i, tmp_q[i], exp_q[i]); end
            end
            if (sel) begin
                vectors++; if ({s_done, s_err} !== {exp_done, exp_err} || s_cnt !== 3'(exp_q.size()) || s_busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd%0d_final: got de=%b cnt=%0d want %b %0d", it, {s_done, s_err}, s_cnt, {exp_done, exp_err}, exp_q.size()); end
            end else begin
                vectors++; if ({done, err} !== {exp_done, exp_err} || cnt !== 12'(exp_q.size()) || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd%0d_final: got de=%b cnt=%0d want %b %0d", it, {done, err}, cnt, {exp_done, exp_err}, exp_q.size()); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_halt_program;
        test_back_to_back;
        test_overflow;
        test_reset_midword;
        test_idle_done_rx;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter CANT_BITS_INSTRUCTION, default 32, meaning the instruction word width.
REQ-002 The block SHALL have parameter CANT_BITS_DATO_UART, default 8, meaning the received byte width.
REQ-003 The block SHALL have parameter CANT_BITS_ADDR, default 11, meaning the instruction memory address width.
REQ-004 The block SHALL have port i_clock, input, width 1: the single clock. All state changes on its rising edge.
REQ-005 The block SHALL have port i_soft_reset, input, width 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_start, input, width 1: one-cycle request to begin a program load.
REQ-007 The block SHALL have port i_rx_data, input, width CANT_BITS_DATO_UART: the received byte.
REQ-008 The block SHALL have port i_rx_valid, input, width 1: one-cycle strobe marking i_rx_data valid.
REQ-009 The block SHALL have port o_mem_write_enable, output, width 1: instruction memory write strobe.
REQ-010 The block SHALL have port o_mem_addr, output, width CANT_BITS_ADDR: the write address.
REQ-011 The block SHALL have port o_mem_data, output, width CANT_BITS_INSTRUCTION: the assembled instruction.
REQ-012 The block SHALL have outputs o_busy, o_done and o_error, each width 1: load in progress, HALT stored, and memory overflow.
REQ-013 The block SHALL have port o_instr_count, output, width CANT_BITS_ADDR+1: the number of words written in the current load.

Function
REQ-014 The block SHALL implement the states IDLE, RECV, WRITE, DONE and ERROR.
REQ-015 In IDLE, the block SHALL ignore i_rx_valid.
REQ-016 In IDLE, i_start SHALL clear the address, byte counter and o_instr_count, and move to RECV.
REQ-017 In RECV, each i_rx_valid SHALL capture i_rx_data MSB-first: byte 0 to bits 31:24, byte 3 to bits 7:0.
REQ-018 The 2-bit byte counter SHALL wrap from 3 to 0.
REQ-019 Capture of byte 3 at edge N SHALL enter WRITE, with o_mem_write_enable high for exactly the cycle after edge N.
REQ-020 While in WRITE, o_mem_addr and o_mem_data SHALL be stable and registered, and o_instr_count SHALL increment at the end of WRITE.
REQ-021 From WRITE, the block SHALL go to DONE if the word is 0x00000000 (HALT); the address SHALL be left unchanged.
REQ-022 From WRITE with a non-HALT word, the block SHALL go to ERROR if o_mem_addr equals 2^CANT_BITS_ADDR-1 (no address wrap-around is permitted).
REQ-023 Otherwise, from WRITE the address SHALL increment and the block SHALL return to RECV.
REQ-024 An i_rx_valid arriving during WRITE with a non-HALT word SHALL be captured as byte 0 of the next word.
REQ-025 An i_rx_valid arriving during WRITE with a HALT word SHALL be dropped.
REQ-026 o_busy SHALL be high in RECV and WRITE only.
REQ-027 o_done SHALL be held high in DONE, and o_error SHALL be held high in ERROR.
REQ-028 i_start in DONE or ERROR SHALL restart the load exactly as from IDLE. An i_start arriving in RECV or WRITE SHALL be ignored.
REQ-029 A partial word (fewer than 4 bytes) SHALL never be written.
REQ-030 o_mem_write_enable SHALL be low in every state except WRITE.

Reset
REQ-031 Asserting i_soft_reset low SHALL immediately force IDLE, even in the middle of a word or during WRITE.
REQ-032 During reset, o_mem_write_enable, o_busy, o_done and o_error SHALL be 0.
REQ-033 During reset, o_mem_addr, o_mem_data, o_instr_count and the byte counter SHALL be 0.
REQ-034 After reset is released, the first action SHALL be taken on the first rising edge that sees i_start.

Structure
REQ-035 The state encodings, the HALT constant (32'h00000000) and the byte-counter width SHALL be placed in a shared package, which is reused by control and the debug unit.
REQ-036 The byte-to-word shift/assembly register SHALL be one sub-module, word_assembler, with ports: clock, reset, clear, load strobe, byte in, word out, and a count==3 flag.
REQ-037 The FSM, address counter and write strobe SHALL stay in instruction_loader.

Verification
REQ-038 The bench SHALL cover: start; bytes 00 01 10 C0 -> one write of 0x000110C0 at address 0; o_instr_count=1; state RECV.
REQ-039 The bench SHALL cover: words 0x00221804, 0x1283000C, then 0x00000000 -> writes at addresses 0, 1, 2; o_done=1; o_instr_count=3.
REQ-040 The bench SHALL cover: byte strobe coincident with the WRITE cycle of 0x00221821 -> that byte is the MSB of the next word.
REQ-041 The bench SHALL cover: CANT_BITS_ADDR=2 with four non-HALT words -> the fourth word is written at address 3, then o_error=1 and no further writes occur.
REQ-042 The bench SHALL cover: reset asserted after 2 bytes -> all outputs 0 immediately; a new start plus 4 bytes writes at address 0 with no leftover bytes.
REQ-043 The bench SHALL cover: i_rx_valid pulses in IDLE and DONE -> no write strobe and no counter change.
